// File: rtl/pc_branch_unit_if.sv
// Bus between decode/ALU side and the PC/branch unit.
// Master drives decoded controls and ALU results; slave returns PC and status.
interface pc_branch_unit_if #(
  parameter int W  = 8,
  parameter int PW = 10,
  parameter int LW = 4
);
  logic          Start;
  logic          Stall;
  logic          HaltReq;
  logic          BranchEn;
  logic [W-1:0]  AluOut;
  logic          AluZero;
  logic          AluParity;
  logic          AluOdd;
  logic          FlagEn;
  logic [LW-1:0] TgtIdx;
  logic          LutWe;
  logic [LW-1:0] LutAddr;
  logic [PW-1:0] LutData;
  logic [PW-1:0] PC;
  logic          Running;
  logic          Done;
  logic          Taken;
  logic          FlagZero;
  logic          FlagParity;
  logic          FlagOdd;

  modport master (
    output Start, Stall, HaltReq, BranchEn,
    output AluOut, AluZero, AluParity, AluOdd, FlagEn,
    output TgtIdx, LutWe, LutAddr, LutData,
    input  PC, Running, Done, Taken,
    input  FlagZero, FlagParity, FlagOdd
  );

  modport slave (
    input  Start, Stall, HaltReq, BranchEn,
    input  AluOut, AluZero, AluParity, AluOdd, FlagEn,
    input  TgtIdx, LutWe, LutAddr, LutData,
    output PC, Running, Done, Taken,
    output FlagZero, FlagParity, FlagOdd
  );
endinterface

// File: rtl/pc_branch_unit.sv
// PC sequencing and BGZ branch resolution with a writable target LUT.
// All outputs are registered; the LUT is read before the same-edge write.
module pc_branch_unit #(
  parameter int W  = 8,
  parameter int PW = 10,
  parameter int LW = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  pc_branch_unit_if.slave   bus
);

  localparam int DEPTH = 2 ** LW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic          taken_q, taken_d;
  logic [2:0]    flags_q, flags_d;
  logic [PW-1:0] lut_q [DEPTH];
  logic [PW-1:0] lut_d [DEPTH];

  logic          br_hit;
  logic          flag_le;
  logic          unused_alu;

  assign br_hit     = bus.BranchEn & bus.AluOut[0];
  assign unused_alu = ^bus.AluOut[W-1:1];

  assign flag_le = (state_q == RUN) & bus.FlagEn
                 & ~bus.Stall & ~bus.HaltReq;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        pc_d = '0;
        if (bus.Start) state_d = RUN;
      end
      RUN: begin
        if (bus.HaltReq) begin
          state_d = DONE;
        end else if (!bus.Stall) begin
          if (br_hit) begin
            pc_d    = lut_q[bus.TgtIdx];
            taken_d = 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.Start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (flag_le)
      flags_d = {bus.AluZero, bus.AluParity, bus.AluOdd};
  end

  // Branch lookup above uses lut_q, so a same-edge write is not seen.
  always_comb begin
    lut_d = lut_q;
    if (bus.LutWe)
      lut_d[bus.LutAddr] = bus.LutData;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      taken_q <= 1'b0;
      flags_q <= '0;
      lut_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      flags_q <= flags_d;
      lut_q   <= lut_d;
    end
  end

  assign bus.PC         = pc_q;
  assign bus.Running    = (state_q == RUN);
  assign bus.Done       = (state_q == DONE);
  assign bus.Taken      = taken_q;
  assign bus.FlagZero   = flags_q[2];
  assign bus.FlagParity = flags_q[1];
  assign bus.FlagOdd    = flags_q[0];

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed vector table, then random
// stimulus against a behavioural model.
module tb_pc_branch_unit;

  localparam int W  = 8;
  localparam int PW = 10;
  localparam int LW = 4;

  logic clk;
  logic rst_n;

  pc_branch_unit_if #(.W(W), .PW(PW), .LW(LW)) bus ();

  pc_branch_unit #(.W(W), .PW(PW), .LW(LW)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 run, 2 done
  int       m_state;
  int       m_pc;
  bit       m_taken;
  bit [2:0] m_flags;
  int       m_lut [16];

  typedef struct {
    logic          rst;
    logic          start;
    logic          stall;
    logic          halt;
    logic          br;
    logic [W-1:0]  alu;
    logic [LW-1:0] tgt;
    logic          we;
    logic [LW-1:0] wa;
    logic [PW-1:0] wd;
    logic          fe;
    logic [2:0]    zpo;
    logic [PW-1:0] e_pc;
    logic          e_run;
    logic          e_done;
    logic          e_tk;
    logic [2:0]    e_flg;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    logic rst, logic start, logic stall, logic halt, logic br,
    logic [W-1:0] alu, logic [LW-1:0] tgt,
    logic we, logic [LW-1:0] wa, logic [PW-1:0] wd,
    logic fe, logic [2:0] zpo,
    logic [PW-1:0] e_pc, logic e_run, logic e_done,
    logic e_tk, logic [2:0] e_flg);
    vec_t v;
    v.rst = rst; v.start = start; v.stall = stall;
    v.halt = halt; v.br = br; v.alu = alu; v.tgt = tgt;
    v.we = we; v.wa = wa; v.wd = wd; v.fe = fe; v.zpo = zpo;
    v.e_pc = e_pc; v.e_run = e_run; v.e_done = e_done;
    v.e_tk = e_tk; v.e_flg = e_flg;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(vec_t v);
    rst_n         = v.rst;
    bus.Start     = v.start;
    bus.Stall     = v.stall;
    bus.HaltReq   = v.halt;
    bus.BranchEn  = v.br;
    bus.AluOut    = v.alu;
    bus.TgtIdx    = v.tgt;
    bus.LutWe     = v.we;
    bus.LutAddr   = v.wa;
    bus.LutData   = v.wd;
    bus.FlagEn    = v.fe;
    bus.AluZero   = v.zpo[2];
    bus.AluParity = v.zpo[1];
    bus.AluOdd    = v.zpo[0];
  endtask

  // Reference behaviour computed from the current (pre-edge) inputs.
  task automatic model_step();
    int old_tgt;
    if (!rst_n) begin
      m_state = 0;
      m_pc    = 0;
      m_taken = 0;
      m_flags = 0;
      foreach (m_lut[i]) m_lut[i] = 0;
      return;
    end
    old_tgt = m_lut[bus.TgtIdx];
    if (m_state == 1 && bus.FlagEn && !bus.Stall && !bus.HaltReq)
      m_flags = {bus.AluZero, bus.AluParity, bus.AluOdd};
    m_taken = 0;
    if (m_state == 0) begin
      m_pc = 0;
      if (bus.Start) m_state = 1;
    end else if (m_state == 2) begin
      if (bus.Start) begin
        m_state = 1;
        m_pc    = 0;
      end
    end else if (bus.HaltReq) begin
      m_state = 2;
    end else if (bus.Stall) begin
      m_pc = m_pc;
    end else if (bus.BranchEn && bus.AluOut[0]) begin
      m_pc    = old_tgt;
      m_taken = 1;
    end else begin
      m_pc = (m_pc + 1) % (1 << PW);
    end
    if (bus.LutWe) m_lut[bus.LutAddr] = bus.LutData;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    vt.push_back(mk(0,0,0,0,0,8'h00,0,0,0,10'h000,0,3'b000, 10'h000,0,0,0,3'b000));
    vt.push_back(mk(0,0,0,0,0,8'h00,0,0,0,10'h000,0,3'b000, 10'h000,0,0,0,3'b000));
    vt.push_back(mk(1,1,0,0,0,8'h00,0,0,0,10'h000,0,3'b000, 10'h000,1,0,0,3'b000));
    for (int i = 1; i <= 5; i++)
      vt.push_back(mk(1,0,0,0,0,8'h00,0,0,0,10'h000,0,3'b000, PW'(i),1,0,0,3'b000));
    vt.push_back(mk(1,0,0,1,0,8'h00,0,0,0,10'h000,0,3'b000, 10'h005,0,1,0,3'b000));
    vt.push_back(mk(1,0,0,0,0,8'h00,0,0,0,10'h000,0,3'b000, 10'h005,0,1,0,3'b000));
    vt.push_back(mk(1,1,0,0,0,8'h00,0,0,0,10'h000,0,3'b000, 10'h000,1,0,0,3'b000));
    vt.push_back(mk(1,0,0,0,0,8'h00,0,1,3,10'h120,0,3'b000, 10'h001,1,0,0,3'b000));
    vt.push_back(mk(1,0,0,0,0,8'h00,0,1,4,10'h007,0,3'b000, 10'h002,1,0,0,3'b000));
    for (int i = 3; i <= 7; i++)
      vt.push_back(mk(1,0,0,0,0,8'h00,0,0,0,10'h000,0,3'b000, PW'(i),1,0,0,3'b000));
    vt.push_back(mk(1,0,0,0,1,8'h01,3,0,0,10'h000,0,3'b000, 10'h120,1,0,1,3'b000));
    vt.push_back(mk(1,0,0,0,1,8'h01,4,0,0,10'h000,0,3'b000, 10'h007,1,0,1,3'b000));
    vt.push_back(mk(1,0,0,0,1,8'h00,3,0,0,10'h000,0,3'b000, 10'h008,1,0,0,3'b000));
    vt.push_back(mk(1,0,0,0,1,8'hFE,3,0,0,10'h000,0,3'b000, 10'h009,1,0,0,3'b000));
    vt.push_back(mk(1,0,1,1,1,8'h01,3,0,0,10'h000,0,3'b000, 10'h009,0,1,0,3'b000));
    vt.push_back(mk(1,1,0,0,0,8'h00,0,0,0,10'h000,0,3'b000, 10'h000,1,0,0,3'b000));
    vt.push_back(mk(1,0,1,0,1,8'h01,3,0,0,10'h000,0,3'b000, 10'h000,1,0,0,3'b000));
    vt.push_back(mk(1,0,0,0,0,8'h00,0,1,5,10'h3FF,0,3'b000, 10'h001,1,0,0,3'b000));
    vt.push_back(mk(1,0,0,0,0,8'h00,0,1,2,10'h010,0,3'b000, 10'h002,1,0,0,3'b000));
    vt.push_back(mk(1,0,0,0,1,8'h01,5,0,0,10'h000,0,3'b000, 10'h3FF,1,0,1,3'b000));
    vt.push_back(mk(1,0,0,0,0,8'h00,0,0,0,10'h000,0,3'b000, 10'h000,1,0,0,3'b000));
    vt.push_back(mk(1,0,0,0,1,8'h01,2,1,2,10'h055,0,3'b000, 10'h010,1,0,1,3'b000));
    vt.push_back(mk(1,0,0,0,1,8'h01,2,0,0,10'h000,0,3'b000, 10'h055,1,0,1,3'b000));
    vt.push_back(mk(1,0,0,0,0,8'h00,0,0,0,10'h000,1,3'b101, 10'h056,1,0,0,3'b101));
    vt.push_back(mk(1,0,1,0,0,8'h00,0,0,0,10'h000,1,3'b010, 10'h056,1,0,0,3'b101));
    vt.push_back(mk(0,0,0,0,0,8'h00,0,1,2,10'h077,0,3'b000, 10'h000,0,0,0,3'b000));
    vt.push_back(mk(1,1,0,0,0,8'h00,0,0,0,10'h000,0,3'b000, 10'h000,1,0,0,3'b000));
    vt.push_back(mk(1,0,0,0,1,8'h01,2,0,0,10'h000,0,3'b000, 10'h000,1,0,1,3'b000));
    vt.push_back(mk(1,1,0,0,0,8'h00,0,0,0,10'h000,0,3'b000, 10'h001,1,0,0,3'b000));

    for (int n = 0; n < vt.size(); n++) begin
      v = vt[n];
      drive(v);
      tick();
      chk($sformatf("vec%0d pc", n),      32'(bus.PC),      32'(v.e_pc));
      chk($sformatf("vec%0d running", n), 32'(bus.Running), 32'(v.e_run));
      chk($sformatf("vec%0d done", n),    32'(bus.Done),    32'(v.e_done));
      chk($sformatf("vec%0d taken", n),   32'(bus.Taken),   32'(v.e_tk));
      chk($sformatf("vec%0d flags", n),
          32'({bus.FlagZero, bus.FlagParity, bus.FlagOdd}), 32'(v.e_flg));
    end

    for (int n = 0; n < 3000; n++) begin
      rst_n         = ($urandom_range(0, 199) != 0);
      bus.Start     = ($urandom_range(0, 9) == 0);
      bus.Stall     = ($urandom_range(0, 4) == 0);
      bus.HaltReq   = ($urandom_range(0, 39) == 0);
      bus.BranchEn  = ($urandom_range(0, 2) == 0);
      bus.AluOut    = W'($urandom);
      bus.TgtIdx    = LW'($urandom);
      bus.LutWe     = ($urandom_range(0, 3) == 0);
      bus.LutAddr   = LW'($urandom);
      bus.LutData   = PW'($urandom);
      bus.FlagEn    = $urandom_range(0, 1) == 1;
      bus.AluZero   = $urandom_range(0, 1) == 1;
      bus.AluParity = $urandom_range(0, 1) == 1;
      bus.AluOdd    = $urandom_range(0, 1) == 1;
      tick();
      chk("rnd pc",      32'(bus.PC),      32'(m_pc));
      chk("rnd running", 32'(bus.Running), 32'(m_state == 1));
      chk("rnd done",    32'(bus.Done),    32'(m_state == 2));
      chk("rnd taken",   32'(bus.Taken),   32'(m_taken));
      chk("rnd flags",
          32'({bus.FlagZero, bus.FlagParity, bus.FlagOdd}), 32'(m_flags));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
